// File: rtl/sm_accumulator.sv
// Sign-magnitude accumulator: sums a programmed number of terms, returns the total over valid/ready.
// Define SM_ACC_SAT_EN for per-step saturation with a sticky ovf flag; otherwise the sum wraps.
module sm_accumulator #(
    parameter int Width    = 15,
    parameter int AccWidth = 24,
    parameter int CntWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CntWidth-1:0] len,
    input  logic [Width:0]      din,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [AccWidth:0]   dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                ovf
);

`ifdef SM_ACC_SAT_EN
    localparam int SW = AccWidth + 2;
`else
    localparam int SW = AccWidth + 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t               state;
    logic [CntWidth-1:0]  rem;
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] term;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] nxt;
    logic [SW-1:0]        mag_ext;
    logic                 last;

    // Negative zero negates to zero, so it needs no special case.
    always_comb begin
        mag_ext = {{(SW - Width){1'b0}}, din[Width-1:0]};
        term    = din[Width] ? -mag_ext : mag_ext;
        sum     = acc + term;
    end

`ifdef SM_ACC_SAT_EN
    localparam logic signed [SW-1:0] MaxV = {2'b00, {AccWidth{1'b1}}};
    localparam logic signed [SW-1:0] MinV = -MaxV;

    logic clamp;

    always_comb begin
        clamp = 1'b0;
        nxt   = sum;
        if (sum > MaxV) begin
            nxt   = MaxV;
            clamp = 1'b1;
        end else if (sum < MinV) begin
            nxt   = MinV;
            clamp = 1'b1;
        end
    end
`else
    // SW is AccWidth+1 here, so the adder itself wraps modulo 2^(AccWidth+1).
    always_comb begin
        nxt = sum;
    end

    assign ovf = 1'b0;
`endif

    // Out-of-range magnitude only arises from the wrapped -2^AccWidth code.
    function automatic logic [AccWidth:0] to_sm(input logic signed [SW-1:0] v);
        logic [SW-1:0] m;
        m = v[SW-1] ? -v : v;
        if (m[SW-1:AccWidth] != '0) begin
            return {v[SW-1], {AccWidth{1'b1}}};
        end
        return {v[SW-1] && (m != '0), m[AccWidth-1:0]};
    endfunction

    assign last     = (rem == CntWidth'(1));
    assign in_ready = (state == ACC);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            acc       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
`ifdef SM_ACC_SAT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        rem <= len;
`ifdef SM_ACC_SAT_EN
                        ovf <= 1'b0;
`endif
                        if (len == '0) begin
                            dout      <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= nxt;
                        rem <= rem - CntWidth'(1);
`ifdef SM_ACC_SAT_EN
                        ovf <= ovf | clamp;
`endif
                        if (last) begin
                            dout      <= to_sm(nxt);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Bench for sm_accumulator: default instance plus an AccWidth=16 instance for overflow cases.
// Expected results come from an integer model queued at stimulus time.
module tb_sm_accumulator;

`ifdef SM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
    localparam logic [24:0] WIDE_D = 25'h0FFFF;
    localparam logic WIDE_O = 1'b1;
`else
    localparam bit SAT = 1'b0;
    localparam logic [24:0] WIDE_D = 25'h18003;
    localparam logic WIDE_O = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, in_valid, out_ready;
    logic [7:0]  len;
    logic [15:0] din;
    logic        in_ready, out_valid, busy, ovf;
    logic [24:0] dout;

    logic        w_start, w_in_valid, w_out_ready;
    logic [7:0]  w_len;
    logic [15:0] w_din;
    logic        w_in_ready, w_out_valid, w_busy, w_ovf;
    logic [16:0] w_dout;

    sm_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    sm_accumulator #(.Width(15), .AccWidth(16), .CntWidth(8)) u_wide (
        .clk(clk), .rst(rst), .start(w_start), .len(w_len),
        .din(w_din), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .dout(w_dout), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .busy(w_busy), .ovf(w_ovf)
    );

    typedef struct packed {
        logic [24:0] d;
        logic        o;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] tv[64];
    int          tn;

    function automatic exp_t model(input int aw);
        longint s, lim, m, mag;
        bit o;
        exp_t r;
        s = 0;
        o = 1'b0;
        lim = (longint'(1) << aw) - 1;
        m = longint'(1) << (aw + 1);
        for (int i = 0; i < tn; i++) begin
            mag = longint'(tv[i][14:0]);
            s += tv[i][15] ? -mag : mag;
            if (SAT) begin
                if (s > lim) begin s = lim; o = 1'b1; end
                else if (s < -lim) begin s = -lim; o = 1'b1; end
            end else begin
                s = ((s % m) + m) % m;
                if (s > lim) s -= m;
            end
        end
        r.o = o;
        if (s < 0) begin
            mag = -s;
            if (mag > lim) mag = lim;
            r.d = 25'((longint'(1) << aw) | mag);
        end else begin
            r.d = 25'(s);
        end
        return r;
    endfunction

    task automatic go(input bit w, input logic [7:0] n);
        @(negedge clk);
        if (w) begin w_start = 1'b1; w_len = n; end
        else begin start = 1'b1; len = n; end
        @(negedge clk);
        w_start = 1'b0;
        start = 1'b0;
    endtask

    task automatic put(input bit w, input logic [15:0] d);
        if (w) begin w_in_valid = 1'b1; w_din = d; end
        else begin in_valid = 1'b1; din = d; end
        @(negedge clk);
        w_in_valid = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic take(input bit w);
        if (w) w_out_ready = 1'b1;
        else out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic wait_out(input bit w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if ((w ? w_out_valid : out_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic job(input bit w, input bit gap);
        sb.push_back(model(w ? 16 : 24));
        go(w, 8'(tn));
        for (int i = 0; i < tn; i++) begin
            if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
            put(w, tv[i]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vectors++;
        if (dout !== 25'h0) begin miscompares++; $display("FAIL rst_dout got %h want 0", dout); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b want 0", ovf); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        tn = 3;
        tv[0] = 16'h0064;
        tv[1] = 16'h801E;
        tv[2] = 16'h0005;
        job(0, 0);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency got %b want 1", out_valid); end
        e = sb.pop_front();
        vectors++;
        if (dout !== e.d || dout !== 25'h00004B) begin
            miscompares++; $display("FAIL basic_dout got %h want %h", dout, e.d);
        end
        vectors++;
        if (ovf !== e.o) begin miscompares++; $display("FAIL basic_ovf got %b want %b", ovf, e.o); end
        take(0);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_release got v=%b b=%b want 0 0", out_valid, busy);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (dout !== 25'h00004B) begin miscompares++; $display("FAIL idle_hold got %h want 4b", dout); end
    endtask

    task automatic test_len0;
        go(0, 8'd0);
        vectors++;
        if (out_valid !== 1'b1 || dout !== 25'h0) begin
            miscompares++; $display("FAIL len0_out got v=%b d=%h want 1 0", out_valid, dout);
        end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len = 8'd3;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || dout !== 25'h0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL len0_stall got v=%b d=%h r=%b b=%b want 1 0 0 1", out_valid, dout, in_ready, busy);
            end
        end
        start = 1'b0;
        take(0);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL len0_release got v=%b b=%b r=%b want 0 0 0", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_zero;
        tn = 2;
        tv[0] = 16'h0032;
        tv[1] = 16'h8032;
        job(0, 0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || dout !== e.d || dout !== 25'h0) begin
            miscompares++; $display("FAIL cancel_zero got v=%b d=%h want 1 %h", out_valid, dout, e.d);
        end
        take(0);
        tn = 1;
        tv[0] = 16'h8000;
        job(0, 0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || dout !== e.d || dout !== 25'h0) begin
            miscompares++; $display("FAIL neg_zero got v=%b d=%h want 1 %h", out_valid, dout, e.d);
        end
        take(0);
    endtask

    task automatic test_wide;
        tn = 3;
        for (int i = 0; i < 3; i++) tv[i] = 16'h7FFF;
        job(1, 0);
        e = sb.pop_front();
        vectors++;
        if (w_out_valid !== 1'b1 || {8'h0, w_dout} !== e.d || {8'h0, w_dout} !== WIDE_D) begin
            miscompares++; $display("FAIL wide_dout got v=%b d=%h want 1 %h", w_out_valid, w_dout, WIDE_D);
        end
        vectors++;
        if (w_ovf !== e.o || w_ovf !== WIDE_O) begin
            miscompares++; $display("FAIL wide_ovf got %b want %b", w_ovf, WIDE_O);
        end
        take(1);
    endtask

    task automatic test_gapped;
        tn = 3;
        for (int i = 0; i < 3; i++) tv[i] = 16'h0001;
        sb.push_back(model(24));
        go(0, 8'd3);
        put(0, tv[0]);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++; $display("FAIL gap_hold got r=%b v=%b want 1 0", in_ready, out_valid);
            end
            @(negedge clk);
        end
        put(0, tv[1]);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL gap_ready got %b want 1", in_ready); end
        put(0, tv[2]);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || dout !== e.d || dout !== 25'h3) begin
            miscompares++; $display("FAIL gap_result got v=%b d=%h want 1 3", out_valid, dout);
        end
        take(0);
    endtask

    task automatic test_abort;
        go(0, 8'd4);
        put(0, 16'h0009);
        put(0, 16'h0009);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_idle got v=%b r=%b b=%b want 0 0 0", out_valid, in_ready, busy);
        end
        tn = 1;
        tv[0] = 16'h0007;
        job(0, 0);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || dout !== e.d || dout !== 25'h7) begin
            miscompares++; $display("FAIL abort_fresh got v=%b d=%h want 1 7", out_valid, dout);
        end
        take(0);
    endtask

    task automatic test_back_to_back;
        bit ok;
        for (int j = 0; j < 12; j++) begin
            bit w;
            w = (j % 2) == 1;
            tn = $urandom_range(1, 8);
            for (int i = 0; i < tn; i++) begin
                tv[i][15] = 1'($urandom_range(0, 1));
                tv[i][14:0] = w ? 15'($urandom_range(20000, 32767)) : 15'($urandom);
            end
            job(w, 1);
            wait_out(w, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL b2b_timeout job %0d got no out_valid want 1", j);
            end else begin
                vectors++;
                if ((w ? {8'h0, w_dout} : dout) !== e.d) begin
                    miscompares++;
                    $display("FAIL b2b_dout job %0d got %h want %h", j, w ? {8'h0, w_dout} : dout, e.d);
                end
                vectors++;
                if ((w ? w_ovf : ovf) !== e.o) begin
                    miscompares++; $display("FAIL b2b_ovf job %0d got %b want %b", j, w ? w_ovf : ovf, e.o);
                end
                take(w);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; len = '0; din = '0; in_valid = 1'b0; out_ready = 1'b0;
        w_start = 1'b0; w_len = '0; w_din = '0; w_in_valid = 1'b0; w_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len0();
        test_zero();
        test_wide();
        test_gapped();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
